// File: rtl/sdio_data_response_if.sv
// Signal bundle between the SD data phy/function side and the write CRC-status responder.
// The master side drives the phy status inputs and observes the DAT0 response outputs.
interface sdio_data_response_if;
    logic       i_sd_stb;
    logic       i_finished;
    logic       i_write_flag;
    logic       i_crc_good;
    logic       i_busy;
    logic       o_dat0_oe;
    logic       o_dat0;
    logic       o_active;
    logic       o_done;
    logic       o_timeout;
    logic [7:0] o_crc_err_count;

    modport master (
        output i_sd_stb, i_finished, i_write_flag, i_crc_good, i_busy,
        input  o_dat0_oe, o_dat0, o_active, o_done, o_timeout, o_crc_err_count
    );

    modport slave (
        input  i_sd_stb, i_finished, i_write_flag, i_crc_good, i_busy,
        output o_dat0_oe, o_dat0, o_active, o_done, o_timeout, o_crc_err_count
    );
endinterface

// File: rtl/sdio_data_response.sv
// SDIO write-block CRC status token and DAT0 busy signalling, sequenced on SD clock strobes.
// Any drop of i_finished mid-response releases DAT0 on the next clk_x2 edge.
module sdio_data_response #(
    parameter int unsigned NCRC         = 2,
    parameter logic [15:0] BUSY_TIMEOUT = 16'd65535
) (
    input  logic                 clk_x2,
    input  logic                 rst,
    sdio_data_response_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT_NCRC,
        START,
        STATUS,
        END_BIT,
        BUSY,
        RELEASE,
        WAIT_CLR
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_fin_d;
    logic        r_pend, w_pend_next;
    logic        r_crc_good, w_crc_good_next;
    logic [15:0] r_cnt, w_cnt_next;
    logic [1:0]  r_bit, w_bit_next;
    logic        r_timed_out, w_timed_out_next;
    logic        r_done, w_done_next;
    logic        r_timeout, w_timeout_next;
    logic [7:0]  r_err_cnt, w_err_cnt_next;

    logic        w_rise;
    logic        w_start;
    logic        w_abort;
    logic [15:0] w_cnt_inc;
    logic        w_dat0_oe;
    logic        w_dat0;

    assign w_rise    = bus.i_finished & ~r_fin_d;
    assign w_start   = w_rise & bus.i_write_flag;
    assign w_cnt_inc = r_cnt + 16'd1;
    assign w_abort   = ~bus.i_finished && (r_state != IDLE) && (r_state != WAIT_CLR);

    always_ff @(posedge clk_x2) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fin_d     <= 1'b0;
            r_pend      <= 1'b0;
            r_crc_good  <= 1'b0;
            r_cnt       <= 16'd0;
            r_bit       <= 2'd0;
            r_timed_out <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_state     <= w_state_next;
            r_fin_d     <= bus.i_finished;
            r_pend      <= w_pend_next;
            r_crc_good  <= w_crc_good_next;
            r_cnt       <= w_cnt_next;
            r_bit       <= w_bit_next;
            r_timed_out <= w_timed_out_next;
            r_done      <= w_done_next;
            r_timeout   <= w_timeout_next;
            r_err_cnt   <= w_err_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pend_next      = r_pend;
        w_crc_good_next  = r_crc_good;
        w_cnt_next       = r_cnt;
        w_bit_next       = r_bit;
        w_timed_out_next = r_timed_out;
        w_done_next      = 1'b0;
        w_timeout_next   = 1'b0;
        w_err_cnt_next   = r_err_cnt;

        if (w_abort) begin
            w_state_next     = IDLE;
            w_pend_next      = 1'b0;
            w_cnt_next       = 16'd0;
            w_bit_next       = 2'd0;
            w_timed_out_next = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // The rising edge may fall between strobes; hold it until the next one.
                    if (!bus.i_finished) begin
                        w_pend_next = 1'b0;
                    end else if (w_start) begin
                        w_pend_next     = 1'b1;
                        w_crc_good_next = bus.i_crc_good;
                    end
                    if ((w_start || r_pend) && bus.i_finished && bus.i_sd_stb) begin
                        w_state_next = WAIT_NCRC;
                        w_pend_next  = 1'b0;
                        w_cnt_next   = 16'd0;
                    end
                end
                WAIT_NCRC: begin
                    if (bus.i_sd_stb) begin
                        if (w_cnt_inc >= 16'(NCRC)) begin
                            w_state_next = START;
                            w_cnt_next   = 16'd0;
                        end else begin
                            w_cnt_next = w_cnt_inc;
                        end
                    end
                end
                START: begin
                    if (bus.i_sd_stb) begin
                        w_state_next = STATUS;
                        w_bit_next   = 2'd0;
                        if (!r_crc_good && (r_err_cnt != 8'hFF)) begin
                            w_err_cnt_next = r_err_cnt + 8'd1;
                        end
                    end
                end
                STATUS: begin
                    if (bus.i_sd_stb) begin
                        if (r_bit == 2'd2) begin
                            w_state_next = END_BIT;
                            w_bit_next   = 2'd0;
                        end else begin
                            w_bit_next = r_bit + 2'd1;
                        end
                    end
                end
                END_BIT: begin
                    if (bus.i_sd_stb) begin
                        w_state_next     = r_crc_good ? BUSY : RELEASE;
                        w_cnt_next       = 16'd0;
                        w_timed_out_next = 1'b0;
                    end
                end
                BUSY: begin
                    // Timeout wins over a simultaneous release of i_busy.
                    if (bus.i_sd_stb) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == BUSY_TIMEOUT) begin
                            w_state_next     = RELEASE;
                            w_timeout_next   = 1'b1;
                            w_timed_out_next = 1'b1;
                        end else if (!bus.i_busy) begin
                            w_state_next = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (bus.i_sd_stb) begin
                        w_state_next     = WAIT_CLR;
                        w_done_next      = ~r_timed_out;
                        w_timed_out_next = 1'b0;
                        w_cnt_next       = 16'd0;
                    end
                end
                WAIT_CLR: begin
                    if (bus.i_sd_stb && !bus.i_finished) begin
                        w_state_next = IDLE;
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    // STATUS token is 010 for good CRC and 101 for bad: only the middle bit differs in sense.
    always_comb begin
        w_dat0_oe = 1'b0;
        w_dat0    = 1'b1;
        case (r_state)
            START: begin
                w_dat0_oe = 1'b1;
                w_dat0    = 1'b0;
            end
            STATUS: begin
                w_dat0_oe = 1'b1;
                w_dat0    = ((r_bit == 2'd1) == r_crc_good);
            end
            END_BIT: begin
                w_dat0_oe = 1'b1;
                w_dat0    = 1'b1;
            end
            BUSY: begin
                w_dat0_oe = 1'b1;
                w_dat0    = 1'b0;
            end
            RELEASE: begin
                w_dat0_oe = 1'b1;
                w_dat0    = 1'b1;
            end
            default: begin
                w_dat0_oe = 1'b0;
                w_dat0    = 1'b1;
            end
        endcase
    end

    assign bus.o_dat0_oe       = w_dat0_oe;
    assign bus.o_dat0          = w_dat0;
    assign bus.o_active        = (r_state != IDLE) && (r_state != WAIT_CLR);
    assign bus.o_done          = r_done;
    assign bus.o_timeout       = r_timeout;
    assign bus.o_crc_err_count = r_err_cnt;
endmodule

// File: tb/tb_sdio_data_response.sv
// Bench for sdio_data_response: table of write/read responses scored per strobe period,
// plus hand sequences for abort, mid-sequence reset and error-count saturation.
module tb_sdio_data_response;
    logic clk_x2 = 1'b0;
    logic rst;
    bit   stb_en;
    int   checks = 0;
    int   errors = 0;

    sdio_data_response_if bus();
    sdio_data_response_if bus_to();

    sdio_data_response #(.NCRC(2), .BUSY_TIMEOUT(16'd65535)) dut (
        .clk_x2 (clk_x2),
        .rst    (rst),
        .bus    (bus)
    );

    sdio_data_response #(.NCRC(2), .BUSY_TIMEOUT(16'd4)) dut_to (
        .clk_x2 (clk_x2),
        .rst    (rst),
        .bus    (bus_to)
    );

    assign bus_to.i_sd_stb     = bus.i_sd_stb;
    assign bus_to.i_finished   = bus.i_finished;
    assign bus_to.i_write_flag = bus.i_write_flag;
    assign bus_to.i_crc_good   = bus.i_crc_good;
    assign bus_to.i_busy       = bus.i_busy;

    always #5 clk_x2 = ~clk_x2;

    typedef struct {
        bit wr;
        bit crc;
        int busy_n;
        bit stall;
        bit exp_done;
        bit exp_to_tmo;
        bit exp_err_inc;
    } vec_t;

    bit exp_q[$];
    bit to_q[$];
    int oe_cnt, gap_cnt, done_cnt, tmo_cnt, to_done_cnt, to_tmo_cnt;
    bit active_seen;
    int exp_err = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Strobe every second clk_x2 cycle while enabled.
    initial begin
        bus.i_sd_stb = 1'b0;
        forever begin
            @(posedge clk_x2);
            #1;
            if (stb_en) bus.i_sd_stb = ~bus.i_sd_stb;
            else        bus.i_sd_stb = 1'b0;
        end
    end

    // One sample per strobe period, taken in the cycle whose edge ends the period.
    always @(negedge clk_x2) begin
        bit e;
        if (bus.o_done)    done_cnt++;
        if (bus.o_timeout) tmo_cnt++;
        if (bus.o_active)  active_seen = 1'b1;
        if (bus.i_sd_stb) begin
            if (bus.o_dat0_oe) begin
                oe_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dat0_unexpected: got drive of %0d, expected no drive", bus.o_dat0);
                end else begin
                    e = exp_q.pop_front();
                    check("dat0", int'(bus.o_dat0), int'(e));
                end
            end else if (bus.o_active) begin
                gap_cnt++;
            end
        end
    end

    always @(negedge clk_x2) begin
        bit e;
        if (bus_to.o_done)    to_done_cnt++;
        if (bus_to.o_timeout) to_tmo_cnt++;
        if (bus_to.i_sd_stb && bus_to.o_dat0_oe) begin
            if (to_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL to_dat0_unexpected: got drive of %0d, expected no drive", bus_to.o_dat0);
            end else begin
                e = to_q.pop_front();
                check("to_dat0", int'(bus_to.o_dat0), int'(e));
            end
        end
    end

    // Expected DAT0 per driven strobe period: start, 3-bit token, end bit, busy zeros, release.
    task automatic push_seq(input bit to_inst, input bit crc, input int nbusy);
        bit [2:0] st;
        bit q[$];
        st = crc ? 3'b010 : 3'b101;
        q.push_back(1'b0);
        q.push_back(st[2]);
        q.push_back(st[1]);
        q.push_back(st[0]);
        q.push_back(1'b1);
        if (crc) for (int i = 0; i < nbusy; i++) q.push_back(1'b0);
        q.push_back(1'b1);
        foreach (q[i]) begin
            if (to_inst) to_q.push_back(q[i]);
            else         exp_q.push_back(q[i]);
        end
    endtask

    task automatic clear_counts();
        oe_cnt = 0; gap_cnt = 0; done_cnt = 0; tmo_cnt = 0;
        to_done_cnt = 0; to_tmo_cnt = 0; active_seen = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  b_eff;
        int  to_b;
        bit  stalled;
        bit  fin;
        b_eff   = (v.busy_n < 1) ? 1 : v.busy_n;
        to_b    = v.exp_to_tmo ? 4 : b_eff;
        stalled = 1'b0;
        fin     = 1'b0;
        clear_counts();
        if (v.exp_err_inc) exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
        bus.i_write_flag = v.wr;
        bus.i_crc_good   = v.crc;
        bus.i_busy       = (v.busy_n > 1);
        if (v.wr) begin
            push_seq(1'b0, v.crc, b_eff);
            push_seq(1'b1, v.crc, to_b);
        end
        @(posedge clk_x2); #1;
        bus.i_finished = 1'b1;
        if (v.wr) begin
            for (int c = 0; c < 400 && !fin; c++) begin
                @(posedge clk_x2); #1;
                if (v.busy_n > 1 && oe_cnt >= 4 + v.busy_n) bus.i_busy = 1'b0;
                if (v.stall && !stalled && oe_cnt == 6) begin
                    stalled = 1'b1;
                    stb_en  = 1'b0;
                    repeat (60) @(posedge clk_x2);
                    #1;
                    check("stall_oe",     int'(bus.o_dat0_oe),    1);
                    check("stall_dat0",   int'(bus.o_dat0),       0);
                    check("stall_to_oe",  int'(bus_to.o_dat0_oe), 1);
                    check("stall_to_tmo", to_tmo_cnt,             0);
                    stb_en = 1'b1;
                end
                if (exp_q.size() == 0 && to_q.size() == 0 && !bus.o_active && !bus_to.o_active) fin = 1'b1;
            end
            check("seq_complete", int'(fin), 1);
            repeat (4) @(posedge clk_x2); #1;
            check("ncrc_gap", gap_cnt, 2);
        end else begin
            repeat (30) @(posedge clk_x2); #1;
            check("read_active", int'(active_seen), 0);
            check("read_oe",     oe_cnt,            0);
        end
        check("done_pulses",    done_cnt,    int'(v.exp_done));
        check("timeout_pulses", tmo_cnt,     0);
        check("to_done_pulses", to_done_cnt, int'(v.exp_done && !v.exp_to_tmo));
        check("to_tmo_pulses",  to_tmo_cnt,  int'(v.exp_to_tmo));
        check("crc_err_count",  int'(bus.o_crc_err_count), exp_err);
        active_seen = 1'b0;
        repeat (10) @(posedge clk_x2); #1;
        check("no_restart", int'(active_seen), 0);
        bus.i_finished = 1'b0;
        bus.i_busy     = 1'b0;
        repeat (6) @(posedge clk_x2); #1;
        check("left_expected", exp_q.size() + to_q.size(), 0);
        exp_q.delete();
        to_q.delete();
        $display("seq %0d: wr=%0d crc=%0d busy=%0d done=%0d to_timeout=%0d err_count=%0d",
                 idx, v.wr, v.crc, v.busy_n, done_cnt, to_tmo_cnt, bus.o_crc_err_count);
    endtask

    // Launch a good write and wait until n driven strobe periods have been seen.
    task automatic launch_and_wait(input int n);
        bit hit;
        hit = 1'b0;
        clear_counts();
        bus.i_write_flag = 1'b1;
        bus.i_crc_good   = 1'b1;
        bus.i_busy       = 1'b0;
        push_seq(1'b0, 1'b1, 1);
        push_seq(1'b1, 1'b1, 1);
        @(posedge clk_x2); #1;
        bus.i_finished = 1'b1;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge clk_x2); #1;
            if (oe_cnt >= n) hit = 1'b1;
        end
        check("launch_reached", int'(hit), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vec_t sat;
        vecs[0] = '{wr:1, crc:1, busy_n:0,  stall:0, exp_done:1, exp_to_tmo:0, exp_err_inc:0};
        vecs[1] = '{wr:1, crc:0, busy_n:0,  stall:0, exp_done:1, exp_to_tmo:0, exp_err_inc:1};
        vecs[2] = '{wr:0, crc:1, busy_n:0,  stall:0, exp_done:0, exp_to_tmo:0, exp_err_inc:0};
        vecs[3] = '{wr:1, crc:1, busy_n:3,  stall:0, exp_done:1, exp_to_tmo:0, exp_err_inc:0};
        vecs[4] = '{wr:1, crc:1, busy_n:10, stall:0, exp_done:1, exp_to_tmo:1, exp_err_inc:0};
        vecs[5] = '{wr:1, crc:1, busy_n:3,  stall:1, exp_done:1, exp_to_tmo:0, exp_err_inc:0};
        vecs[6] = '{wr:0, crc:0, busy_n:0,  stall:0, exp_done:0, exp_to_tmo:0, exp_err_inc:0};
        vecs[7] = '{wr:1, crc:0, busy_n:2,  stall:0, exp_done:1, exp_to_tmo:0, exp_err_inc:1};
        vecs[8] = '{wr:1, crc:1, busy_n:1,  stall:0, exp_done:1, exp_to_tmo:0, exp_err_inc:0};
        sat     = '{wr:1, crc:0, busy_n:0,  stall:0, exp_done:1, exp_to_tmo:0, exp_err_inc:1};

        rst = 1'b1;
        stb_en = 1'b1;
        bus.i_finished = 1'b0;
        bus.i_write_flag = 1'b0;
        bus.i_crc_good = 1'b0;
        bus.i_busy = 1'b0;
        clear_counts();
        repeat (4) @(posedge clk_x2); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk_x2); #1;
        check("rst_oe",      int'(bus.o_dat0_oe),       0);
        check("rst_dat0",    int'(bus.o_dat0),          1);
        check("rst_active",  int'(bus.o_active),        0);
        check("rst_done",    int'(bus.o_done),          0);
        check("rst_timeout", int'(bus.o_timeout),       0);
        check("rst_err",     int'(bus.o_crc_err_count), 0);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Abort: i_finished drops during STATUS, DAT0 released on the next edge, no pulses.
        launch_and_wait(2);
        check("abort_pre_oe", int'(bus.o_dat0_oe), 1);
        bus.i_finished = 1'b0;
        @(posedge clk_x2); #1;
        check("abort_oe",     int'(bus.o_dat0_oe),    0);
        check("abort_active", int'(bus.o_active),     0);
        check("abort_to_oe",  int'(bus_to.o_dat0_oe), 0);
        exp_q.delete();
        to_q.delete();
        repeat (20) @(posedge clk_x2); #1;
        check("abort_done",    done_cnt + to_done_cnt, 0);
        check("abort_timeout", tmo_cnt + to_tmo_cnt,   0);
        $display("seq abort: oe=%0d active=%0d", bus.o_dat0_oe, bus.o_active);

        // Reset mid-sequence releases DAT0 on the same edge and clears the error count.
        launch_and_wait(1);
        rst = 1'b1;
        @(posedge clk_x2); #1;
        check("midrst_oe",     int'(bus.o_dat0_oe),       0);
        check("midrst_active", int'(bus.o_active),        0);
        check("midrst_err",    int'(bus.o_crc_err_count), 0);
        check("midrst_to_oe",  int'(bus_to.o_dat0_oe),    0);
        exp_err = 0;
        bus.i_finished = 1'b0;
        @(posedge clk_x2); #1;
        rst = 1'b0;
        exp_q.delete();
        to_q.delete();
        repeat (6) @(posedge clk_x2); #1;
        $display("seq reset: oe=%0d err_count=%0d", bus.o_dat0_oe, bus.o_crc_err_count);

        for (int i = 0; i < 300; i++) run_vec(100 + i, sat);
        check("sat_err",    int'(bus.o_crc_err_count),    255);
        check("sat_to_err", int'(bus_to.o_crc_err_count), 255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdio_data_response.md
SDIO_DATA_RESPONSE -- requirements
Module: sdio_data_response

Interface
REQ-001 SHALL have parameter NCRC, default 2, meaning the number of SD clock periods from the end of a write data block to the CRC status start bit.
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 16'd65535, meaning the maximum number of SD clock periods DAT0 is held busy.
REQ-003 SHALL have port clk_x2  input  1  system clock; all logic SHALL be synchronous to its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_sd_stb  input  1  one-clk_x2 pulse per SD clock period; marks the bit boundary.
REQ-006 SHALL have port i_finished  input  1  level from the data phy: the data block plus its CRC is complete.
REQ-007 SHALL have port i_write_flag  input  1  current transfer is host-to-device.
REQ-008 SHALL have port i_crc_good  input  1  data phy CRC result, valid while i_finished=1.
REQ-009 SHALL have port i_busy  input  1  function side is still committing write data.
REQ-010 SHALL have port o_dat0_oe  output  1  DAT0 output enable.
REQ-011 SHALL have port o_dat0  output  1  DAT0 output value.
REQ-012 SHALL have port o_active  output  1  a response sequence is in progress.
REQ-013 SHALL have port o_done  output  1  one-cycle pulse when the sequence completes normally.
REQ-014 SHALL have port o_timeout  output  1  one-cycle pulse when the busy timeout expires.
REQ-015 SHALL have port o_crc_err_count  output  8  saturating count of bad-CRC status tokens sent.

Function
REQ-016 SHALL use the states IDLE, WAIT_NCRC, START, STATUS, END_BIT, BUSY, RELEASE, WAIT_CLR.
REQ-017 SHALL register i_finished and, in IDLE, on a rising edge of i_finished with i_write_flag=1, latch i_crc_good and go to WAIT_NCRC; a rising edge with i_write_flag=0 SHALL be ignored.
REQ-018 SHALL change state and DAT0 outputs only on cycles with i_sd_stb=1, except for the abort path (REQ-027) and reset.
REQ-019 WAIT_NCRC SHALL keep o_dat0_oe=0 for NCRC strobes, then go to START.
REQ-020 START SHALL drive oe=1 and dat0=0 for one strobe period.
REQ-021 STATUS SHALL drive 3 bits MSB first, one per strobe: 010 if the latched CRC was good, 101 if it was bad.
REQ-022 On entry to STATUS with a bad CRC, o_crc_err_count SHALL increment, saturating at 255.
REQ-023 END_BIT SHALL drive dat0=1 for one strobe period, then go to BUSY if the CRC was good, otherwise to RELEASE.
REQ-024 BUSY SHALL drive dat0=0 for at least one strobe period and SHALL stay in BUSY while i_busy=1.
REQ-025 BUSY SHALL count strobes in a 16-bit counter; on reaching BUSY_TIMEOUT it SHALL pulse o_timeout and go to RELEASE regardless of i_busy.
REQ-026 RELEASE SHALL drive dat0=1 for one strobe period, then set oe=0, pulse o_done (unless exited by timeout), and go to WAIT_CLR.
REQ-027 In any state other than IDLE or WAIT_CLR, if i_finished=0 the block SHALL abort: on the next clk_x2 edge it SHALL set oe=0, go to IDLE, and emit neither o_done nor o_timeout.
REQ-028 WAIT_CLR SHALL return to IDLE when i_finished=0; a new sequence SHALL NOT start without a fresh rising edge.
REQ-029 o_active SHALL be 1 in every state except IDLE and WAIT_CLR.
REQ-030 If i_sd_stb never asserts, the block SHALL hold its state indefinitely with no timeout progress.

Reset
REQ-031 On rst=1 the block SHALL go to IDLE with o_dat0_oe=0, o_dat0=1, o_active=0, o_done=0, o_timeout=0, o_crc_err_count=0, and the busy counter and all latches cleared.
REQ-032 A reset asserted mid-sequence SHALL release DAT0 (oe=0) on the same clk_x2 edge.

Verification
REQ-033 Good write: i_sd_stb every 2nd cycle, i_finished rises with crc_good=1 and i_busy=0 -> 2 released strobes, then DAT0 = 0,0,1,0,1,0(busy),1, then oe=0 and o_done pulses once.
REQ-034 Bad CRC: crc_good=0 -> DAT0 = 0,1,0,1,1,1 with no busy, o_crc_err_count 0->1, o_done pulses.
REQ-035 Busy hold: i_busy=1 for 10 strobes after END_BIT -> DAT0 stays 0 for 10 strobes, then 1, and o_done pulses.
REQ-036 Timeout: BUSY_TIMEOUT=4 with i_busy stuck at 1 -> 4 busy strobes, o_timeout pulses, o_done stays 0, DAT0 is released.
REQ-037 Abort and saturation: i_finished drops during STATUS -> oe=0 on the next edge and no pulses; 300 bad-CRC sequences -> o_crc_err_count=255.
REQ-038 Read ignore: i_finished rises with i_write_flag=0 -> oe stays 0 and o_active stays 0.
